// File: rtl/div_pkg.sv
// Shared constants for the multicycle signed divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DZ   = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Multicycle signed restoring divider with MIPS DIV semantics (HI = remainder, LO = quotient).
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_t       state, state_d;
  logic [WIDTH:0]   rem, rem_d;
  logic [WIDTH-1:0] quo, quo_d;
  logic [WIDTH-1:0] dvsr, dvsr_d;
  logic             sign_q, sign_q_d;
  logic             sign_r, sign_r_d;
  logic [CNT_W-1:0] count, count_d;
  logic             busy_d, done_d, div_zero_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_lo;

  // One restoring step: shift the dividend MSB into the remainder and trial-compare.
  always_comb begin
    rem_sh = (rem << 1) | (WIDTH+1)'(quo[WIDTH-1]);
    fits   = (rem_sh >= {1'b0, dvsr});
    rem_lo = rem[WIDTH-1:0];
  end

  // Next-state and next-register values.
  always_comb begin
    state_d    = state;
    rem_d      = rem;
    quo_d      = quo;
    dvsr_d     = dvsr;
    sign_q_d   = sign_q;
    sign_r_d   = sign_r;
    count_d    = count;
    busy_d     = busy;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_out;
    lo_d       = lo_out;

    case (state)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (b == '0) begin
            state_d = DZ;
          end else begin
            state_d  = CALC;
            quo_d    = a[WIDTH-1] ? -a : a;
            dvsr_d   = b[WIDTH-1] ? -b : b;
            sign_q_d = a[WIDTH-1] ^ b[WIDTH-1];
            sign_r_d = a[WIDTH-1];
            rem_d    = '0;
            count_d  = CNT_W'(WIDTH - 1);
          end
        end
      end
      CALC: begin
        rem_d   = fits ? (rem_sh - {1'b0, dvsr}) : rem_sh;
        quo_d   = {quo[WIDTH-2:0], fits};
        count_d = count - CNT_W'(1);
        if (count == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = sign_q ? -quo : quo;
        hi_d    = sign_r ? -rem_lo : rem_lo;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      DZ: begin
        done_d     = 1'b1;
        div_zero_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      state    <= state_d;
      rem      <= rem_d;
      quo      <= quo_d;
      dvsr     <= dvsr_d;
      sign_q   <= sign_q_d;
      sign_r   <= sign_r_d;
      count    <= count_d;
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= div_zero_d;
      hi_out   <= hi_d;
      lo_out   <= lo_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: random and directed divisions against an arithmetic model.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           at;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Reference: divide magnitudes with wide integers, then apply MIPS sign rules.
  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y, input int at);
    exp_t   e;
    longint sx, sy, mx, my, q, r;
    sx = $signed(x);
    sy = $signed(y);
    e.at = at;
    if (y == '0) begin
      e.hi = last_hi;
      e.lo = last_lo;
      e.dz = 1'b1;
    end else begin
      mx = (sx < 0) ? -sx : sx;
      my = (sy < 0) ? -sy : sy;
      q  = mx / my;
      r  = mx % my;
      if ((sx < 0) != (sy < 0)) q = -q;
      if (sx < 0) r = -r;
      e.lo = q[W-1:0];
      e.hi = r[W-1:0];
      e.dz = 1'b0;
      last_hi = e.hi;
      last_lo = e.lo;
    end
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("lo", lo_out, e.lo);
        chk("hi", hi_out, e.hi);
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("latency", 32'(cyc), 32'(e.at));
        chk("busy_at_done", 32'(busy), 32'(0));
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(x, y, cyc + ((y == '0) ? 1 : W + 1));
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    chk("busy_after_start", 32'(busy), 32'(1));
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", 32'(k >= 200), 32'(0));
    if (k >= 200) sb.delete();
    @(negedge clk);
    chk("hi_held", hi_out, last_hi);
    chk("lo_held", lo_out, last_lo);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_dz", 32'(div_zero), 32'(0));
    chk("rst_hi", hi_out, 32'(0));
    chk("rst_lo", lo_out, 32'(0));
    @(negedge clk);
    reset = 1'b1;

    issue(32'd100, 32'd7);            wait_idle();
    issue(32'hFFFFFF9C, 32'd7);       wait_idle();
    issue(32'd100, 32'hFFFFFFF9);     wait_idle();
    issue(32'h80000000, 32'hFFFFFFFF); wait_idle();
    issue(32'd5, 32'd9);              wait_idle();
    issue(32'd100, 32'd7);            wait_idle();
    issue(32'd42, 32'd0);             wait_idle();

    // start during CALC is ignored
    issue(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    a = 32'd1;
    b = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // start held high: second division begins on the IDLE edge that shows done
    @(negedge clk);
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    push_exp(32'd100, 32'd7, n + W + 1);
    a = 32'hFFFFFFCE;
    b = 32'd6;
    push_exp(32'hFFFFFFCE, 32'd6, n + W + 2 + W + 1);
    repeat (W + 2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // reset mid-operation aborts with no done
    issue(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    last_hi = '0;
    last_lo = '0;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_hi", hi_out, 32'(0));
    chk("midrst_lo", lo_out, 32'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'd9, 32'd3);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 9) == 0) ? 32'h80000000 : 32'($urandom);
      issue(ra, rb);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
